// File: rtl/id_imm_pkg.sv
// ============================================================================
// Module : id_imm_pkg
// Brief  : Immediate kinds, LEGv8 opcode constants and the legal R-type table
//          (compiled only with ID_ILLEGAL_OP_DETECT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package id_imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_ALU   = 3'd1,
    IMM_DT    = 3'd2,
    IMM_CB    = 3'd3,
    IMM_B     = 3'd4,
    IMM_SHAMT = 3'd5
  } imm_kind_t;

  // D-format and shift opcodes, instr[31:21]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  // I-format opcodes, instr[31:22]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
  // CB-format opcodes, instr[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // B-format opcodes, instr[31:26]
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;

`ifdef ID_ILLEGAL_OP_DETECT_EN
  localparam int NUM_RTYPE = 10;
  localparam logic [10:0] RTYPE_OPS [NUM_RTYPE] = '{
    11'b10001011000,  // ADD
    11'b11001011000,  // SUB
    11'b10001010000,  // AND
    11'b10101010000,  // ORR
    11'b11001010000,  // EOR
    11'b10101011000,  // ADDS
    11'b11101011000,  // SUBS
    11'b11101010000,  // ANDS
    11'b11010110000,  // BR
    11'b10011011000   // MUL
  };

  function automatic logic is_rtype(input logic [10:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_RTYPE; i++) begin
      if (op == RTYPE_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/id_ex_imm_stage_field_select.sv
// ============================================================================
// Module : imm_field_select
// Brief  : Combinational opcode decode and immediate extraction/extension,
//          longest opcode match first. Honours ID_ILLEGAL_OP_DETECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_field_select
  import id_imm_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr,
  output logic [2:0]        imm_kind,
  output logic [DATA_W-1:0] imm,
  output logic              unmatched
);

  imm_kind_t kind_w;
  logic [DATA_W-1:0] imm_w;

  // Branch offsets stay in words; the EX branch adder applies the <<2.
  always_comb begin
    kind_w = IMM_NONE;
    imm_w  = '0;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      kind_w = IMM_DT;
      imm_w  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:21] == OP_LSL || instr[31:21] == OP_LSR) begin
      kind_w = IMM_SHAMT;
      imm_w  = {{(DATA_W-6){1'b0}}, instr[15:10]};
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_ADDIS ||
                 instr[31:22] == OP_SUBI || instr[31:22] == OP_SUBIS) begin
      kind_w = IMM_ALU;
      imm_w  = {{(DATA_W-12){1'b0}}, instr[21:10]};
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                 instr[31:24] == OP_BCOND) begin
      kind_w = IMM_CB;
      imm_w  = {{(DATA_W-19){instr[23]}}, instr[23:5]};
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      kind_w = IMM_B;
      imm_w  = {{(DATA_W-26){instr[25]}}, instr[25:0]};
    end
  end

`ifdef ID_ILLEGAL_OP_DETECT_EN
  assign unmatched = (kind_w == IMM_NONE) && !is_rtype(instr[31:21]);
`else
  assign unmatched = (kind_w == IMM_NONE);
`endif

  assign imm_kind = kind_w;
  assign imm      = imm_w;

endmodule

`default_nettype wire

// File: rtl/id_ex_imm_stage.sv
// ============================================================================
// Module : id_ex_imm_stage
// Brief  : ID/EX immediate register with flush/stall priority; illegal-opcode
//          flag enabled by ID_ILLEGAL_OP_DETECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_imm_stage
  import id_imm_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  imm,
  output logic [2:0]         imm_kind,
  output logic               out_valid,
  output logic               illegal_op
);

  if (INSTR_W != 32) begin : g_instr_w_check
    $error("id_ex_imm_stage: INSTR_W must be 32");
  end
  if (DATA_W < 32) begin : g_data_w_check
    $error("id_ex_imm_stage: DATA_W must be >= 32");
  end

  logic [2:0]        sel_kind;
  logic [DATA_W-1:0] sel_imm;
  logic              sel_unmatched;

  imm_field_select #(.DATA_W(DATA_W)) u_field_select (
    .instr     (instr[31:0]),
    .imm_kind  (sel_kind),
    .imm       (sel_imm),
    .unmatched (sel_unmatched)
  );

  logic [DATA_W-1:0] imm_d, imm_q;
  logic [2:0]        kind_d, kind_q;
  logic              valid_d, valid_q;
  logic              illegal_d, illegal_q;

  // Gating on in_valid keeps an X instr in a bubble off the outputs.
  always_comb begin
    imm_d     = imm_q;
    kind_d    = kind_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush) begin
      imm_d     = '0;
      kind_d    = IMM_NONE;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      valid_d   = in_valid;
      imm_d     = '0;
      kind_d    = IMM_NONE;
      illegal_d = 1'b0;
      if (in_valid) begin
        imm_d     = sel_imm;
        kind_d    = sel_kind;
        illegal_d = sel_unmatched;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_q     <= '0;
      kind_q    <= IMM_NONE;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      kind_q    <= kind_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign imm       = imm_q;
  assign imm_kind  = kind_q;
  assign out_valid = valid_q;

`ifdef ID_ILLEGAL_OP_DETECT_EN
  assign illegal_op = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
  assign illegal_op     = 1'b0;
`endif

endmodule

`default_nettype wire
